// File: rtl/update_knn20_pkg.sv
// Shared constants and types for the update_knn20 multiplier-sharing datapath.
// Holds operand widths, the multiplier latency and the tag width used by the arbiter.
package update_knn20_pkg;

   localparam int A_W     = 17;
   localparam int B_W     = 15;
   localparam int P_W     = 32;
   localparam int MUL_LAT = 2;
   localparam int ID_W    = 2;

   typedef struct packed {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
   } mul_req_t;

   // Number of occupied pipeline slots; MUL_LAT never exceeds 3, so 2 bits suffice.
   function automatic logic [1:0] slot_count(input logic [MUL_LAT-1:0] v);
      logic [1:0] cnt;
      cnt = 2'd0;
      for (int i = 0; i < MUL_LAT; i++) begin
         cnt = cnt + {1'b0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/update_knn20_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr,
// wrapping around to the lowest index when nothing above the pointer is valid.
module update_knn20_rr_pick
   import update_knn20_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any
);

   // Two passes with constant indices: the upper segment first, then the wrap-around.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && req_valid[i] && (i >= int'(rr_ptr))) begin
            any         = 1'b1;
            grant_idx   = ID_W'(i);
            grant_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && req_valid[i]) begin
            any         = 1'b1;
            grant_idx   = ID_W'(i);
            grant_oh[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/update_knn20_mul_arb.sv
// Round-robin sharing of one 2-cycle pipelined 17x15 multiplier among NUM_REQ requesters,
// with a tag pipeline that returns each product on a single valid/ready response channel.
module update_knn20_mul_arb
   import update_knn20_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*A_W-1:0]   req_a,
   input  logic [NUM_REQ*B_W-1:0]   req_b,
   output logic                     mul_ce,
   output logic [A_W-1:0]           mul_din0,
   output logic [B_W-1:0]           mul_din1,
   input  logic [P_W-1:0]           mul_dout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [P_W-1:0]           rsp_data,
   output logic [1:0]               inflight
);

   logic [NUM_REQ-1:0] grant_oh_s;
   logic [ID_W-1:0]    grant_idx_s;
   logic               any_s;
   logic               xfer_s;
   mul_req_t           sel_s;

   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [MUL_LAT-1:0] vld_q, vld_d;
   logic [ID_W-1:0]    id_q [MUL_LAT];
   logic [ID_W-1:0]    id_d [MUL_LAT];
   logic [1:0]         inflight_q, inflight_d;

   update_knn20_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant_oh  (grant_oh_s),
      .grant_idx (grant_idx_s),
      .any       (any_s)
   );

   // Only a result that is waiting on the response channel freezes the pipeline.
   assign mul_ce    = !(vld_q[MUL_LAT-1] && !rsp_ready);
   assign req_ready = mul_ce ? grant_oh_s : {NUM_REQ{1'b0}};
   assign xfer_s    = any_s && mul_ce;

   // AND-OR operand mux over the one-hot grant; all-zero when nothing is granted.
   always_comb begin
      sel_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_s = sel_s | ({(A_W+B_W){grant_oh_s[i]}} &
                          {req_a[i*A_W +: A_W], req_b[i*B_W +: B_W]});
      end
   end

   assign mul_din0 = sel_s.a;
   assign mul_din1 = sel_s.b;

   // Tag pipeline shift, round-robin pointer advance and occupancy count.
   always_comb begin
      vld_d    = vld_q;
      id_d     = id_q;
      rr_ptr_d = rr_ptr_q;
      if (mul_ce) begin
         vld_d[0] = xfer_s;
         id_d[0]  = xfer_s ? grant_idx_s : '0;
         for (int k = 1; k < MUL_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            id_d[k]  = id_q[k-1];
         end
      end else begin
         vld_d = vld_q;
         id_d  = id_q;
      end
      if (xfer_s) begin
         rr_ptr_d = (grant_idx_s == ID_W'(NUM_REQ-1)) ? '0 : grant_idx_s + 1'b1;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      inflight_d = slot_count(vld_d);
   end

   // State registers with synchronous reset; multiplier data is unreset and ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q      <= '0;
         rr_ptr_q   <= '0;
         inflight_q <= 2'd0;
         for (int k = 0; k < MUL_LAT; k++) begin
            id_q[k] <= '0;
         end
      end else begin
         vld_q      <= vld_d;
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= inflight_d;
         for (int k = 0; k < MUL_LAT; k++) begin
            id_q[k] <= id_d[k];
         end
      end
   end

   assign rsp_valid = vld_q[MUL_LAT-1];
   assign rsp_id    = id_q[MUL_LAT-1];
   assign rsp_data  = mul_dout;
   assign inflight  = inflight_q;

endmodule

// File: tb/tb_update_knn20_mul_arb.sv
// Directed and randomized bench for update_knn20_mul_arb, with a behavioural multiplier
// and a slot-level reference model of arbitration, stall and result ordering.
module tb_update_knn20_mul_arb;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [67:0] req_a;
   logic [59:0] req_b;
   logic        mul_ce;
   logic [16:0] mul_din0;
   logic [14:0] mul_din1;
   logic [31:0] mul_dout;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [31:0] rsp_data;
   logic [1:0]  inflight;

   logic [16:0] ta  [4];
   logic [14:0] tbv [4];

   int checks   = 0;
   int failures = 0;

   int          m_rr;
   int          m_vld  [2];
   int          m_id   [2];
   logic [31:0] m_prod [2];

   logic [16:0] ma_q = 17'd0;
   logic [14:0] mb_q = 15'd0;
   logic [31:0] mp_q = 32'd0;

   update_knn20_mul_arb #(.NUM_REQ(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mul_ce    (mul_ce),
      .mul_din0  (mul_din0),
      .mul_din1  (mul_din1),
      .mul_dout  (mul_dout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .inflight  (inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for update_knn20_mul_g8j: input registers then product register, both on ce.
   always @(posedge clk) begin
      if (mul_ce) begin
         ma_q <= mul_din0;
         mb_q <= mul_din1;
         mp_q <= 32'(ma_q) * 32'(mb_q);
      end
   end
   assign mul_dout = mp_q;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < 4; i++) begin
         req_a[i*17 +: 17] = ta[i];
         req_b[i*15 +: 15] = tbv[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_grant();
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (m_rr + k) % 4;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic m_clear();
      m_rr = 0;
      for (int s = 0; s < 2; s++) begin
         m_vld[s]  = 0;
         m_id[s]   = 0;
         m_prod[s] = 32'd0;
      end
   endtask

   // One clock: check all outputs against the model, advance the model, move to next negedge.
   task automatic step();
      int         g;
      logic [1:0] gi;
      logic       exp_ce;
      logic [3:0] exp_rdy;
      #1;
      exp_ce  = !(m_vld[1] != 0 && !rsp_ready);
      g       = m_grant();
      gi      = 2'(g);
      exp_rdy = (g >= 0 && exp_ce) ? (4'b0001 << g) : 4'b0000;
      chk("mul_ce", 32'(mul_ce), 32'(exp_ce));
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_vld[1]));
      chk("inflight", 32'(inflight), 32'(m_vld[0] + m_vld[1]));
      if (m_vld[1] != 0) begin
         chk("rsp_id", 32'(rsp_id), 32'(m_id[1]));
         chk("rsp_data", rsp_data, m_prod[1]);
      end
      if (reset) begin
         m_clear();
      end else if (exp_ce) begin
         m_vld[1]  = m_vld[0];
         m_id[1]   = m_id[0];
         m_prod[1] = m_prod[0];
         m_vld[0]  = (g >= 0) ? 1 : 0;
         m_id[0]   = (g >= 0) ? g : 0;
         m_prod[0] = (g >= 0) ? 32'(ta[gi]) * 32'(tbv[gi]) : 32'd0;
         if (g >= 0) m_rr = (g + 1) % 4;
      end
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ta[i]  = 17'd0;
         tbv[i] = 15'd0;
      end
      m_clear();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      chk("reset_inflight", 32'(inflight), 32'd0);
      chk("reset_mul_ce", 32'(mul_ce), 32'd1);
      reset = 1'b0;

      // Single op with maximal operands.
      req_valid = 4'b0001; ta[0] = 17'h1FFFF; tbv[0] = 15'h7FFF;
      step();
      req_valid = 4'b0000;
      step();
      #1;
      chk("single_valid", 32'(rsp_valid), 32'd1);
      chk("single_id", 32'(rsp_id), 32'd0);
      chk("single_data", rsp_data, 32'hFFFD8001);
      repeat (2) step();

      // Round robin from a freshly reset pointer.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ta[i]  = 17'($urandom);
         tbv[i] = 15'(i + 1);
      end
      req_valid = 4'hF;
      #1;
      chk("rr_first_grant", 32'(req_ready), 32'h1);
      repeat (12) step();
      req_valid = 4'h0;
      repeat (3) step();

      // Backpressure with two results in flight.
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0010; rsp_ready = 1'b0;
      step();
      req_valid = 4'hF;
      repeat (5) begin
         #1;
         chk("bp_inflight", 32'(inflight), 32'd2);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         step();
      end
      rsp_ready = 1'b1; req_valid = 4'h0;
      repeat (4) step();

      // Pointer at 2 with only req1 and req3 valid.
      req_valid = 4'b0010;
      step();
      req_valid = 4'b1010;
      #1;
      chk("ptr_grant3", 32'(req_ready), 32'h8);
      step();
      #1;
      chk("ptr_grant1", 32'(req_ready), 32'h2);
      step();
      req_valid = 4'h0;
      repeat (3) step();

      // Reset while two ops are in flight.
      req_valid = 4'hF;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0; req_valid = 4'h0;
      #1;
      chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mid_inflight", 32'(inflight), 32'd0);
      step();
      #1;
      chk("rst_mid_valid2", 32'(rsp_valid), 32'd0);
      step();
      req_valid = 4'hF;
      #1;
      chk("rst_mid_grant0", 32'(req_ready), 32'h1);
      step();
      req_valid = 4'h0;
      repeat (3) step();

      // Zero and unit operands interleaved with a stall.
      ta[0] = 17'd0; tbv[0] = 15'h7FFF; ta[1] = 17'd1; tbv[1] = 15'd1;
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000; rsp_ready = 1'b0;
      repeat (2) step();
      #1;
      chk("edge_zero", rsp_data, 32'd0);
      rsp_ready = 1'b1;
      step();
      #1;
      chk("edge_one", rsp_data, 32'd1);
      repeat (2) step();

      // Randomized traffic, backpressure and occasional reset.
      for (int n = 0; n < 400; n++) begin
         req_valid = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            ta[i]  = 17'($urandom);
            tbv[i] = 15'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 96) == 0);
         step();
      end
      reset = 1'b0; req_valid = 4'h0; rsp_ready = 1'b1;
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
